// File: rtl/cpu_run_ctrl.sv
// Run/step/breakpoint sequencer: issues one-cycle clock enables to the core in free-run,
// single-step or paused modes, and halts when the PC hits a breakpoint.
module cpu_run_ctrl #(
    parameter int RATE_DIV        = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run_sw,
    input  logic        step_btn,
    input  logic        bp_en,
    input  logic [31:0] bp_addr,
    input  logic [31:0] pc,
    output logic        cpu_en,
    output logic [1:0]  state,
    output logic        halted,
    output logic [31:0] cycle_cnt
);
    localparam int RW = $clog2(RATE_DIV);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [RW-1:0] RATE_LAST = RW'(RATE_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_PAUSE = 2'b00,
        S_RUN   = 2'b01,
        S_STEP  = 2'b10,
        S_BREAK = 2'b11
    } state_t;

    state_t          state_q, state_n;
    logic            run_sync_p0, run_sync_p1;
    logic            btn_sync_p0, btn_sync_p1, btn_sync_p2;
    logic [DW-1:0]   deb_cnt;
    logic            deb_level;
    logic            step_req;
    logic [RW-1:0]   rate_cnt;
    logic            tick;
    logic            armed, armed_n;
    logic            issue;
    logic            rate_clr;

    // Input synchronisers; btn_sync_p2 is only the previous synced sample for change detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_sync_p0 <= 1'b0;
            run_sync_p1 <= 1'b0;
            btn_sync_p0 <= 1'b0;
            btn_sync_p1 <= 1'b0;
            btn_sync_p2 <= 1'b0;
        end else begin
            run_sync_p0 <= run_sw;
            run_sync_p1 <= run_sync_p0;
            btn_sync_p0 <= step_btn;
            btn_sync_p1 <= btn_sync_p0;
            btn_sync_p2 <= btn_sync_p1;
        end
    end

    // Debouncer: accept a new level only after it has held for the full window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_cnt   <= '0;
            deb_level <= 1'b0;
            step_req  <= 1'b0;
        end else begin
            step_req <= 1'b0;
            if (btn_sync_p1 != btn_sync_p2) begin
                deb_cnt <= '0;
            end else if (deb_cnt != DEB_LAST) begin
                deb_cnt <= deb_cnt + 1'b1;
            end else if (btn_sync_p2 != deb_level) begin
                deb_level <= btn_sync_p2;
                step_req  <= btn_sync_p2;
            end
        end
    end

    assign tick = (state_q == S_RUN) && (rate_cnt == RATE_LAST);

    always_comb begin
        state_n  = state_q;
        armed_n  = armed;
        issue    = 1'b0;
        rate_clr = 1'b0;
        case (state_q)
            S_PAUSE: begin
                if (run_sync_p1) begin
                    state_n  = S_RUN;
                    armed_n  = 1'b0;
                    rate_clr = 1'b1;
                end else if (step_req) begin
                    state_n = S_STEP;
                end
            end
            S_RUN: begin
                if (!run_sync_p1) begin
                    state_n = S_PAUSE;
                end else if (tick) begin
                    if (armed && bp_en && (pc == bp_addr)) begin
                        state_n = S_BREAK;
                    end else begin
                        issue   = 1'b1;
                        armed_n = 1'b1;
                    end
                end
            end
            S_STEP: begin
                issue   = 1'b1;
                state_n = S_PAUSE;
            end
            S_BREAK: begin
                if (step_req) begin
                    state_n = S_STEP;
                end else if (!run_sync_p1) begin
                    state_n = S_PAUSE;
                end
            end
            default: state_n = S_PAUSE;
        endcase
    end

    // Decision registers: enable pulse lands one cycle after the decision
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_PAUSE;
            halted    <= 1'b0;
            armed     <= 1'b0;
            cpu_en    <= 1'b0;
            cycle_cnt <= '0;
            rate_cnt  <= '0;
        end else begin
            state_q <= state_n;
            halted  <= (state_n == S_BREAK);
            armed   <= armed_n;
            cpu_en  <= issue;
            if (issue && (cycle_cnt != 32'hFFFF_FFFF)) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
            if (rate_clr) begin
                rate_cnt <= '0;
            end else if (state_q == S_RUN) begin
                rate_cnt <= tick ? '0 : rate_cnt + 1'b1;
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Randomized bench for cpu_run_ctrl, checked against a transaction-level model of
// run rate, debounced stepping and breakpoint behaviour.
module tb_cpu_run_ctrl;
    localparam int RATE_DIV = 4;
    localparam int DEB      = 8;
    // Cycles from run_sw rising to the first pulse: 2 sync + 1 entry + RATE_DIV count
    localparam int RUN_LAT  = 3 + RATE_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run_sw = 1'b0;
    logic        step_btn = 1'b0;
    logic        bp_en = 1'b0;
    logic [31:0] bp_addr = 32'h0;
    logic [31:0] pc = 32'h0;
    logic        cpu_en;
    logic [1:0]  state;
    logic        halted;
    logic [31:0] cycle_cnt;

    int n_chk = 0;
    int n_fail = 0;
    int pulses = 0;
    int cyc = 0;
    int last_pulse = -1;
    bit gap_en = 0;

    cpu_run_ctrl #(.RATE_DIV(RATE_DIV), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk(clk), .rst(rst), .run_sw(run_sw), .step_btn(step_btn),
        .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
        .cpu_en(cpu_en), .state(state), .halted(halted), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int exp_pulses(input int n);
        return (n >= RUN_LAT) ? (n - RUN_LAT) / RATE_DIV + 1 : 0;
    endfunction

    // One clock: the core model advances pc by one instruction on every enable
    task automatic tick_clk();
        @(negedge clk);
        cyc++;
        if (cpu_en) begin
            pulses++;
            pc = pc + 32'd4;
            if (gap_en && last_pulse >= 0) check_val("run_gap", cyc - last_pulse, RATE_DIV);
            last_pulse = cyc;
        end
    endtask

    task automatic do_reset();
        run_sw   = 1'b0;
        step_btn = 1'b0;
        gap_en   = 0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst        = 1'b0;
        pc         = 32'h0;
        pulses     = 0;
        last_pulse = -1;
    endtask

    task automatic bounce_to(input logic final_v);
        logic v;
        int t;
        v = final_v;
        t = 0;
        while (t < 30) begin
            int seg;
            seg = $urandom_range(1, 3);
            step_btn = v;
            repeat (seg) tick_clk();
            t += seg;
            v = ~v;
        end
        step_btn = final_v;
        repeat (20) tick_clk();
    endtask

    task automatic run_to_break(input logic [31:0] bp, input int k);
        bp_en   = 1'b1;
        bp_addr = bp;
        run_sw  = 1'b1;
        for (int i = 0; i < RUN_LAT + (k + 2) * RATE_DIV && !halted; i++) tick_clk();
        check_val("bp_halted", halted, 1);
        check_val("bp_state", state, 2'b11);
        check_val("bp_pulses", pulses, k);
        check_val("bp_pc", pc, bp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        int base;
        do_reset();
        check_val("rst_state", state, 2'b00);
        check_val("rst_en", cpu_en, 0);
        check_val("rst_halted", halted, 0);
        check_val("rst_cnt", cycle_cnt, 0);

        // Free run at the divided rate, then async reset in the middle of a pulse
        for (int it = 0; it < 3; it++) begin
            n = (it == 0) ? 40 : $urandom_range(20, 60);
            do_reset();
            gap_en = 1;
            run_sw = 1'b1;
            repeat (n) tick_clk();
            check_val("run_pulses", pulses, exp_pulses(n));
            check_val("run_cnt", cycle_cnt, exp_pulses(n));
            check_val("run_state", state, 2'b01);
            for (int i = 0; i < 2 * RATE_DIV && !cpu_en; i++) tick_clk();
            check_val("run_pulse_seen", cpu_en, 1);
            gap_en = 0;
            #1 rst = 1'b1;
            #1;
            check_val("midrst_en", cpu_en, 0);
            check_val("midrst_cnt", cycle_cnt, 0);
            check_val("midrst_state", state, 2'b00);
            run_sw = 1'b0;
            @(negedge clk);
            rst = 1'b0;
        end

        // Bouncing press gives exactly one step; bouncing release gives none
        do_reset();
        bounce_to(1'b1);
        check_val("step_pulses", pulses, 1);
        check_val("step_cnt", cycle_cnt, 1);
        check_val("step_state", state, 2'b00);
        bounce_to(1'b0);
        check_val("release_pulses", pulses, 1);

        // Breakpoints at random word addresses plus the 0x10 case
        for (int it = 0; it < 3; it++) begin
            k = (it == 0) ? 4 : $urandom_range(1, 6);
            do_reset();
            run_to_break(32'(4 * k), k);
            repeat (20) tick_clk();
            check_val("bp_hold_pulses", pulses, k);
            check_val("bp_hold_state", state, 2'b11);
        end

        // Step past the breakpoint from BREAK, then resume by toggling run_sw
        do_reset();
        run_to_break(32'h10, 4);
        pulses = 0;
        step_btn = 1'b1;
        for (int i = 0; i < 40 && state != 2'b10; i++) tick_clk();
        check_val("bstep_state", state, 2'b10);
        check_val("bstep_pre", pulses, 0);
        tick_clk();
        check_val("bstep_en", cpu_en, 1);
        check_val("bstep_after", state, 2'b00);
        check_val("bstep_pulses", pulses, 1);
        check_val("bstep_pc", pc, 32'h14);
        step_btn = 1'b0;
        run_sw = 1'b0;
        repeat (20) tick_clk();
        check_val("bstep_paused", state, 2'b00);
        pulses = 0;
        run_sw = 1'b1;
        repeat (30) tick_clk();
        check_val("resume_pulses", pulses, exp_pulses(30));
        check_val("resume_halted", halted, 0);

        // Resume directly from BREAK at the breakpoint PC: first tick must not re-break
        do_reset();
        run_to_break(32'h10, 4);
        run_sw = 1'b0;
        repeat (10) tick_clk();
        check_val("rearm_state", state, 2'b00);
        check_val("rearm_halted", halted, 0);
        pulses = 0;
        base = cycle_cnt;
        run_sw = 1'b1;
        repeat (RUN_LAT) tick_clk();
        check_val("rearm_first", pulses, 1);
        check_val("rearm_pc", pc, 32'h14);
        repeat (13) tick_clk();
        check_val("rearm_pulses", pulses, exp_pulses(RUN_LAT + 13));
        check_val("rearm_cnt", cycle_cnt, 32'(base + exp_pulses(RUN_LAT + 13)));
        check_val("rearm_nobreak", halted, 0);

        // Saturation of the retired-cycle counter
        do_reset();
        bp_en = 1'b0;
        force dut.cycle_cnt = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.cycle_cnt;
        @(negedge clk);
        check_val("sat_preload", cycle_cnt, 32'hFFFF_FFFE);
        run_sw = 1'b1;
        repeat (RUN_LAT) tick_clk();
        check_val("sat_first", cycle_cnt, 32'hFFFF_FFFF);
        repeat (2 * RATE_DIV + 2) tick_clk();
        check_val("sat_pulses", pulses, 3);
        check_val("sat_hold", cycle_cnt, 32'hFFFF_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
